// File: rtl/enemy_hit_judge.sv
// enemy_hit_judge: bullet/target collision, damage, score and boss game-over latch.
// One bullet position per clk_22 cycle is tested against the boss and four minor enemies;
// at most one target is damaged per hit, followed by a blanking window.
module enemy_hit_judge #(
    parameter int unsigned DMG          = 2,
    parameter int unsigned ENM_HP_INIT  = 20,
    parameter int unsigned BOSS_HP_INIT = 500,
    parameter int unsigned HOLD_CYC     = 2,
    parameter int unsigned KILL_BONUS   = 10
) (
    input  logic        clk_22,
    input  logic        rst,
    input  logic [9:0]  bullet_x,
    input  logic [9:0]  bullet_y,
    input  logic [9:0]  bossx,
    input  logic [9:0]  bossy,
    input  logic [9:0]  enmx1,
    input  logic [9:0]  enmx2,
    input  logic [9:0]  enmx3,
    input  logic [9:0]  enmx4,
    input  logic [9:0]  enmy1,
    input  logic [9:0]  enmy2,
    input  logic [9:0]  enmy3,
    input  logic [9:0]  enmy4,
    output logic [6:0]  enmhp1,
    output logic [6:0]  enmhp2,
    output logic [6:0]  enmhp3,
    output logic [6:0]  enmhp4,
    output logic [9:0]  bosshp,
    output logic        bullet_hit,
    output logic [2:0]  hit_id,
    output logic [15:0] score,
    output logic        boss_down
);

    localparam int unsigned CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [1:0] {
        ST_ARM,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       r_enmhp [4];
    logic [9:0]       r_bosshp;
    logic             r_bullet_hit;
    logic [2:0]       r_hit_id;
    logic [15:0]      r_score;
    logic             r_boss_down;

    logic [10:0] w_bx;
    logic [10:0] w_by;
    logic [10:0] w_bsx;
    logic [10:0] w_bsy;
    logic [10:0] w_ex [4];
    logic [10:0] w_ey [4];
    logic        w_bvalid;
    logic [3:0]  w_enm_hit;
    logic        w_boss_hit;
    logic [6:0]  w_enm_next [4];
    logic [9:0]  w_boss_next;
    logic [2:0]  w_sel_id;
    logic        w_kill;
    logic [16:0] w_score_sum;
    logic [15:0] w_score_next;

    // Zero-extend all coordinates to 11 bits so offsets never wrap.
    assign w_bx  = {1'b0, bullet_x};
    assign w_by  = {1'b0, bullet_y};
    assign w_bsx = {1'b0, bossx};
    assign w_bsy = {1'b0, bossy};
    assign w_ex[0] = {1'b0, enmx1};
    assign w_ex[1] = {1'b0, enmx2};
    assign w_ex[2] = {1'b0, enmx3};
    assign w_ex[3] = {1'b0, enmx4};
    assign w_ey[0] = {1'b0, enmy1};
    assign w_ey[1] = {1'b0, enmy2};
    assign w_ey[2] = {1'b0, enmy3};
    assign w_ey[3] = {1'b0, enmy4};
    assign w_bvalid = (bullet_y != 10'd0);

    // Hitbox tests; |a-b| < k is rewritten as a < b+k and b < a+k to avoid subtraction.
    always_comb begin
        w_enm_hit = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_enm_hit[i] = w_bvalid && (r_enmhp[i] != 7'd0)
                        && (w_bx < w_ex[i] + 11'd15) && (w_ex[i] < w_bx + 11'd15)
                        && (w_by < w_ey[i] + 11'd18) && (w_ey[i] < w_by + 11'd18);
        end
        w_boss_hit = w_bvalid && (r_bosshp != 10'd0) && !r_boss_down
                  && (w_bx <= w_bsx + 11'd41) && (w_bsx <= w_bx + 11'd41)
                  && (w_by <= w_bsy + 11'd24);
    end

    // Priority select (boss first, then enemy1..4) and saturating damage/score.
    always_comb begin
        w_sel_id = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_enm_hit[i]) w_sel_id = 3'(i + 1);
        end
        if (w_boss_hit) w_sel_id = 3'd5;

        for (int i = 0; i < 4; i++) begin
            w_enm_next[i] = (r_enmhp[i] > 7'(DMG)) ? (r_enmhp[i] - 7'(DMG)) : 7'd0;
        end
        w_boss_next = (r_bosshp > 10'(DMG)) ? (r_bosshp - 10'(DMG)) : 10'd0;

        w_kill = 1'b0;
        if (w_sel_id == 3'd5) begin
            w_kill = (w_boss_next == 10'd0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_sel_id == 3'(i + 1)) w_kill = (w_enm_next[i] == 7'd0);
            end
        end

        w_score_sum  = {1'b0, r_score} + 17'd1 + (w_kill ? 17'(KILL_BONUS) : 17'd0);
        w_score_next = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
    end

    // ARM/HOLD/DONE sequencer owning all HP, score and hit registers.
    always_ff @(posedge clk_22) begin
        if (rst) begin
            r_state      <= ST_ARM;
            r_cnt        <= '0;
            for (int i = 0; i < 4; i++) r_enmhp[i] <= 7'(ENM_HP_INIT);
            r_bosshp     <= 10'(BOSS_HP_INIT);
            r_bullet_hit <= 1'b0;
            r_hit_id     <= 3'd0;
            r_score      <= 16'd0;
            r_boss_down  <= 1'b0;
        end else begin
            r_bullet_hit <= 1'b0;
            case (r_state)
                ST_ARM: begin
                    if (w_sel_id != 3'd0) begin
                        r_bullet_hit <= 1'b1;
                        r_hit_id     <= w_sel_id;
                        r_score      <= w_score_next;
                        for (int i = 0; i < 4; i++) begin
                            if (w_sel_id == 3'(i + 1)) r_enmhp[i] <= w_enm_next[i];
                        end
                        if (w_sel_id == 3'd5) r_bosshp <= w_boss_next;
                        if ((w_sel_id == 3'd5) && (w_boss_next == 10'd0)) begin
                            r_boss_down <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_cnt   <= CNT_W'(HOLD_CYC - 1);
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == '0) r_state <= ST_ARM;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_ARM;
                end
            endcase
        end
    end

    assign enmhp1     = r_enmhp[0];
    assign enmhp2     = r_enmhp[1];
    assign enmhp3     = r_enmhp[2];
    assign enmhp4     = r_enmhp[3];
    assign bosshp     = r_bosshp;
    assign bullet_hit = r_bullet_hit;
    assign hit_id     = r_hit_id;
    assign score      = r_score;
    assign boss_down  = r_boss_down;

endmodule
